mux_nx1_rr: RTL and testbench

MUX_NX1_RR -- requirements
Module: mux_nx1_rr

---
 rtl/mux_nx1_rr_pkg.sv | 20 ++
 rtl/mux_nx1_rr_if.sv | 38 +++
 rtl/mux_nx1_rr_arbiter.sv | 49 ++++
 rtl/mux_nx1_rr.sv | 78 +++++++
 tb/tb_mux_nx1_rr.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/mux_nx1_rr_pkg.sv
// Shared types for the N:1 registered multiplexer: mode and control-state enums,
// plus the select-width helper used by every file of the block.
package mux_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } mode_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // A 2-channel mux still needs one select bit.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_nx1_rr_if.sv
// Channel-side and output-side handshake bundle for mux_nx1_rr.
// out_parity exists only when MUX_NX1_RR_PARITY_EN is defined.
interface mux_nx1_rr_if import mux_pkg::*; #(
  parameter int N     = 4,
  parameter int WIDTH = 1
);
  localparam int SEL_W = sel_width(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  mode_e              mode;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]   out_sel;
  logic               out_valid;
  logic               out_ready;
`ifdef MUX_NX1_RR_PARITY_EN
  logic               out_parity;
`endif

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
`ifdef MUX_NX1_RR_PARITY_EN
    output out_parity,
`endif
    output in_ready, out_data, out_sel, out_valid
  );

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
`ifdef MUX_NX1_RR_PARITY_EN
    input  out_parity,
`endif
    input  in_ready, out_data, out_sel, out_valid
  );

endinterface

// File: rtl/mux_nx1_rr_arbiter.sv
// Round-robin arbiter: searches req upward from ptr with wrap, one-hot grant,
// and advances ptr past the winner on every grant.
module rr_arbiter import mux_pkg::*; #(
  parameter int N = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            req,
  input  logic                    en,
  output logic [N-1:0]            grant,
  output logic [sel_width(N)-1:0] grant_idx
);
  localparam int SEL_W = sel_width(N);

  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] idx;
  logic             found;
  int               k;

  // NOTE: every output gets a default first so no path leaves it unassigned
  // (an unassigned path in always_comb would infer a latch).
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      idx = SEL_W'(k);
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  // NOTE: registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/mux_nx1_rr.sv
// N:1 registered multiplexer with fixed-select or round-robin channel choice and
// a one-word output register. Optional out_parity under MUX_NX1_RR_PARITY_EN.
module mux_nx1_rr import mux_pkg::*; #(
  parameter int N     = 4,
  parameter int WIDTH = 1
) (
  input logic         clk,
  input logic         rst_n,
  mux_nx1_rr_if.slave bus
);
  localparam int SEL_W = sel_width(N);

  state_e           state;
  logic             load_ok;
  logic             rr_en;
  logic             fix_hit;
  logic             grant_any;
  logic [N-1:0]     rr_grant;
  logic [N-1:0]     grant;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] grant_idx;
  logic [WIDTH-1:0] sel_data;

  // rst_n gates the grant so no channel sees in_ready while reset is held.
  assign load_ok = rst_n && ((state == ST_EMPTY) || bus.out_ready);
  assign rr_en   = load_ok && (bus.mode == MODE_RR);
  assign fix_hit = load_ok && (bus.mode == MODE_FIXED) &&
                   (int'(bus.sel) < N) && bus.in_valid[bus.sel];

  rr_arbiter #(.N(N)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (bus.in_valid),
    .en       (rr_en),
    .grant    (rr_grant),
    .grant_idx(rr_idx)
  );

  always_comb begin
    grant     = '0;
    grant_idx = rr_idx;
    if (rr_en) begin
      grant = rr_grant;
    end else if (fix_hit) begin
      grant[bus.sel] = 1'b1;
      grant_idx      = bus.sel;
    end
  end

  assign grant_any    = |grant;
  assign bus.in_ready = grant;
  assign sel_data     = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_EMPTY;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_sel   <= '0;
`ifdef MUX_NX1_RR_PARITY_EN
      bus.out_parity <= 1'b0;
`endif
    end else if (grant_any) begin
      // A grant implies load_ok, so this covers both fill and drain-and-refill.
      state         <= ST_FULL;
      bus.out_valid <= 1'b1;
      bus.out_data  <= sel_data;
      bus.out_sel   <= grant_idx;
`ifdef MUX_NX1_RR_PARITY_EN
      bus.out_parity <= ^sel_data;
`endif
    end else if (state == ST_FULL && bus.out_ready) begin
      state         <= ST_EMPTY;
      bus.out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_nx1_rr.sv
// Self-checking bench for mux_nx1_rr: directed vector table and sequences on an
// N=4/WIDTH=1 and an N=3/WIDTH=8 instance, then randomized traffic vs a model.
module tb_mux_nx1_rr;
  import mux_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_nx1_rr_if #(.N(4), .WIDTH(1)) bus_a ();
  mux_nx1_rr_if #(.N(3), .WIDTH(8)) bus_b ();

  mux_nx1_rr #(.N(4), .WIDTH(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mux_nx1_rr #(.N(3), .WIDTH(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    mode_e      mode;
    logic [1:0] sel;
    logic [3:0] valid;
    logic [3:0] data;
    logic       ready;
    logic [3:0] exp_rdy;
    logic       exp_vld;
    logic       exp_d;
    logic [1:0] exp_s;
  } vec_t;

  vec_t vecs[18];

  // Reference model state for bus_a (N=4, WIDTH=1).
  bit m_full;
  bit m_data;
  int m_sel;
  int m_ptr;

  function automatic int model_grant(input mode_e m, input int s, input logic [3:0] v,
                                     input bit full, input bit rdy, input int ptr);
    if (full && !rdy) return -1;
    if (m == MODE_FIXED) return v[s] ? s : -1;
    for (int i = 0; i < 4; i++)
      if (v[(ptr + i) % 4]) return (ptr + i) % 4;
    return -1;
  endfunction

  task automatic step_b(input string name, input mode_e m, input logic [1:0] s,
                        input logic [2:0] v, input logic [23:0] d, input logic [2:0] exp_rdy,
                        input logic exp_vld, input logic [7:0] exp_d, input logic [1:0] exp_s);
    bus_b.mode = m; bus_b.sel = s; bus_b.in_valid = v; bus_b.in_data = d;
    bus_b.out_ready = 1'b1;
    #1;
    check({name, " in_ready"}, 64'(bus_b.in_ready), 64'(exp_rdy));
    @(negedge clk);
    check({name, " out_valid"}, 64'(bus_b.out_valid), 64'(exp_vld));
    if (exp_vld) begin
      check({name, " out_data"}, 64'(bus_b.out_data), 64'(exp_d));
      check({name, " out_sel"}, 64'(bus_b.out_sel), 64'(exp_s));
`ifdef MUX_NX1_RR_PARITY_EN
      check({name, " out_parity"}, 64'(bus_b.out_parity), 64'(^exp_d));
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{MODE_FIXED, 2'd2, 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2};
    vecs[1]  = '{MODE_RR,    2'd0, 4'b1111, 4'b0101, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0};
    vecs[2]  = '{MODE_RR,    2'd0, 4'b1111, 4'b0101, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd1};
    vecs[3]  = '{MODE_RR,    2'd0, 4'b1111, 4'b0101, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2};
    vecs[4]  = '{MODE_RR,    2'd0, 4'b1111, 4'b0101, 1'b1, 4'b1000, 1'b1, 1'b0, 2'd3};
    vecs[5]  = '{MODE_RR,    2'd0, 4'b1111, 4'b0101, 1'b1, 4'b0001, 1'b1, 1'b1, 2'd0};
    vecs[6]  = '{MODE_RR,    2'd0, 4'b1111, 4'b0101, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0};
    vecs[7]  = '{MODE_FIXED, 2'd3, 4'b1111, 4'b0101, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0};
    vecs[8]  = '{MODE_FIXED, 2'd3, 4'b1111, 4'b0101, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0};
    vecs[9]  = '{MODE_FIXED, 2'd3, 4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, 1'b1, 2'd3};
    vecs[10] = '{MODE_FIXED, 2'd1, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0};
    vecs[11] = '{MODE_RR,    2'd0, 4'b0011, 4'b0001, 1'b1, 4'b0010, 1'b1, 1'b0, 2'd1};
    vecs[12] = '{MODE_RR,    2'd0, 4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b1, 2'd2};
    vecs[13] = '{MODE_RR,    2'd0, 4'b0011, 4'b0010, 1'b1, 4'b0001, 1'b1, 1'b0, 2'd0};
    vecs[14] = '{MODE_RR,    2'd0, 4'b0011, 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b1, 2'd1};
    vecs[15] = '{MODE_RR,    2'd0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0};
    vecs[16] = '{MODE_RR,    2'd0, 4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 2'd0};
    vecs[17] = '{MODE_RR,    2'd0, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd0};

    rst_n = 1'b0;
    bus_a.mode = MODE_FIXED; bus_a.sel = '0; bus_a.in_valid = '0; bus_a.in_data = '0;
    bus_a.out_ready = 1'b0;
    bus_b.mode = MODE_FIXED; bus_b.sel = '0; bus_b.in_valid = '0; bus_b.in_data = '0;
    bus_b.out_ready = 1'b1;
    @(negedge clk);
    check("reset out_valid", 64'(bus_a.out_valid), 64'd0);
    check("reset out_data", 64'(bus_a.out_data), 64'd0);
    check("reset out_sel", 64'(bus_a.out_sel), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: fixed load, RR 0..3,0 streaming, backpressure, refill, sparse RR.
    for (int i = 0; i < 18; i++) begin
      bus_a.mode = vecs[i].mode; bus_a.sel = vecs[i].sel;
      bus_a.in_valid = vecs[i].valid; bus_a.in_data = vecs[i].data;
      bus_a.out_ready = vecs[i].ready;
      #1;
      check($sformatf("vec%0d in_ready", i), 64'(bus_a.in_ready), 64'(vecs[i].exp_rdy));
      @(negedge clk);
      check($sformatf("vec%0d out_valid", i), 64'(bus_a.out_valid), 64'(vecs[i].exp_vld));
      if (vecs[i].exp_vld) begin
        check($sformatf("vec%0d out_data", i), 64'(bus_a.out_data), 64'(vecs[i].exp_d));
        check($sformatf("vec%0d out_sel", i), 64'(bus_a.out_sel), 64'(vecs[i].exp_s));
      end
    end

    // Asynchronous reset while FULL with out_data=1 and ptr=1: no clock edge.
    rst_n = 1'b0;
    #1;
    check("async rst out_valid", 64'(bus_a.out_valid), 64'd0);
    check("async rst out_data", 64'(bus_a.out_data), 64'd0);
    check("async rst out_sel", 64'(bus_a.out_sel), 64'd0);
    check("async rst ptr", 64'(dut_a.u_arb.ptr), 64'd0);
    check("async rst in_ready", 64'(bus_a.in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against the model.
    m_full = 0; m_data = 0; m_sel = 0; m_ptr = 0;
    for (int c = 0; c < 400; c++) begin
      int g;
      mode_e m;
      m = mode_e'($urandom_range(0, 1));
      bus_a.mode = m;
      bus_a.sel = 2'($urandom_range(0, 3));
      bus_a.in_valid = 4'($urandom);
      bus_a.in_data = 4'($urandom);
      bus_a.out_ready = ($urandom_range(0, 3) != 0);
      g = model_grant(m, int'(bus_a.sel), bus_a.in_valid, m_full, bus_a.out_ready, m_ptr);
      #1;
      check($sformatf("rand%0d in_ready", c), 64'(bus_a.in_ready),
            (g >= 0) ? (64'd1 << g) : 64'd0);
      if (g >= 0) begin
        m_full = 1; m_data = bus_a.in_data[g]; m_sel = g;
        if (m == MODE_RR) m_ptr = (g + 1) % 4;
      end else if (bus_a.out_ready) begin
        m_full = 0;
      end
      @(negedge clk);
      check($sformatf("rand%0d out_valid", c), 64'(bus_a.out_valid), 64'(m_full));
      if (m_full) begin
        check($sformatf("rand%0d out_data", c), 64'(bus_a.out_data), 64'(m_data));
        check($sformatf("rand%0d out_sel", c), 64'(bus_a.out_sel), 64'(m_sel));
      end
    end

    // N=3 instance: out-of-range select, parity values, RR wrap from N-1 to 0.
    do_reset();
    step_b("b sel3", MODE_FIXED, 2'd3, 3'b111, {8'h01, 8'h5A, 8'hA5}, 3'b000, 1'b0, 8'h00, 2'd0);
    step_b("b sel0", MODE_FIXED, 2'd0, 3'b111, {8'h01, 8'h5A, 8'hA5}, 3'b001, 1'b1, 8'hA5, 2'd0);
    step_b("b sel2", MODE_FIXED, 2'd2, 3'b111, {8'h01, 8'h5A, 8'hA5}, 3'b100, 1'b1, 8'h01, 2'd2);
    step_b("b rr2",  MODE_RR,    2'd0, 3'b100, {8'h33, 8'h5A, 8'hA5}, 3'b100, 1'b1, 8'h33, 2'd2);
    step_b("b wrap", MODE_RR,    2'd0, 3'b111, {8'h33, 8'h5A, 8'hA5}, 3'b001, 1'b1, 8'hA5, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
